// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon-style RAM port between the instruction
// fetch requester (I, read only) and the load/store requester (D).
// D normally wins. After MAX_STREAK back-to-back D grants with I waiting,
// I is granted next. Every output is taken directly from a register.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest,
  output logic                grant_d
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int CNT_W    = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RDWAIT, ST_ACK} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   mem_address_reg, mem_address_next;
  logic                mem_read_reg, mem_read_next;
  logic                mem_write_reg, mem_write_next;
  logic [DATA_W-1:0]   mem_writedata_reg, mem_writedata_next;
  logic [BE_W-1:0]     mem_byteenable_reg, mem_byteenable_next;
  logic                cmd_write_reg, cmd_write_next;
  logic                grant_d_reg, grant_d_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic [CNT_W-1:0]    rd_cnt_reg, rd_cnt_next;
  logic                i_ack_reg, i_ack_next;
  logic                d_ack_reg, d_ack_next;
  logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic                win_d;

  // D wins unless fetch has waited through a full streak of data grants
  assign win_d = d_req && !(i_req && (streak_reg == STREAK_W'(MAX_STREAK)));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: one command in flight at a time, no preemption
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (i_req || d_req) state_next = ST_ISSUE;
      ST_ISSUE:  if (!mem_waitrequest) state_next = cmd_write_reg ? ST_ACK : ST_RDWAIT;
      ST_RDWAIT: if (rd_cnt_reg == CNT_W'(1)) state_next = ST_ACK;
      ST_ACK:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and command latch
  always_comb begin
    mem_address_next    = mem_address_reg;
    mem_read_next       = mem_read_reg;
    mem_write_next      = mem_write_reg;
    mem_writedata_next  = mem_writedata_reg;
    mem_byteenable_next = mem_byteenable_reg;
    cmd_write_next      = cmd_write_reg;
    grant_d_next        = grant_d_reg;
    streak_next         = streak_reg;
    rd_cnt_next         = rd_cnt_reg;
    i_rdata_next        = i_rdata_reg;
    d_rdata_next        = d_rdata_reg;
    i_ack_next          = 1'b0;
    d_ack_next          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_d_next = win_d;
          if (win_d) begin
            mem_address_next    = d_addr;
            mem_read_next       = ~d_write;
            mem_write_next      = d_write;
            mem_writedata_next  = d_write ? d_wdata : '0;
            mem_byteenable_next = d_write ? d_byteenable : '1;
            cmd_write_next      = d_write;
            // streak only grows while fetch is actually waiting
            if (!i_req)
              streak_next = '0;
            else if (streak_reg != STREAK_W'(MAX_STREAK))
              streak_next = streak_reg + STREAK_W'(1);
          end else begin
            mem_address_next    = i_addr;
            mem_read_next       = 1'b1;
            mem_write_next      = 1'b0;
            mem_writedata_next  = '0;
            mem_byteenable_next = '1;
            cmd_write_next      = 1'b0;
            streak_next         = '0;
          end
        end
      end
      ST_ISSUE: begin
        // command stays on the bus unchanged until the RAM takes it
        if (!mem_waitrequest) begin
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          if (cmd_write_reg) d_ack_next  = 1'b1;
          else               rd_cnt_next = CNT_W'(RD_LATENCY);
        end
      end
      ST_RDWAIT: begin
        rd_cnt_next = rd_cnt_reg - CNT_W'(1);
        if (rd_cnt_reg == CNT_W'(1)) begin
          if (grant_d_reg) begin
            d_rdata_next = mem_readdata;
            d_ack_next   = 1'b1;
          end else begin
            i_rdata_next = mem_readdata;
            i_ack_next   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and command registers; reset abandons any in-flight command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address_reg    <= '0;
      mem_read_reg       <= 1'b0;
      mem_write_reg      <= 1'b0;
      mem_writedata_reg  <= '0;
      mem_byteenable_reg <= '0;
      cmd_write_reg      <= 1'b0;
      grant_d_reg        <= 1'b0;
      streak_reg         <= '0;
      rd_cnt_reg         <= '0;
      i_ack_reg          <= 1'b0;
      d_ack_reg          <= 1'b0;
      i_rdata_reg        <= '0;
      d_rdata_reg        <= '0;
    end else begin
      mem_address_reg    <= mem_address_next;
      mem_read_reg       <= mem_read_next;
      mem_write_reg      <= mem_write_next;
      mem_writedata_reg  <= mem_writedata_next;
      mem_byteenable_reg <= mem_byteenable_next;
      cmd_write_reg      <= cmd_write_next;
      grant_d_reg        <= grant_d_next;
      streak_reg         <= streak_next;
      rd_cnt_reg         <= rd_cnt_next;
      i_ack_reg          <= i_ack_next;
      d_ack_reg          <= d_ack_next;
      i_rdata_reg        <= i_rdata_next;
      d_rdata_reg        <= d_rdata_next;
    end
  end

  assign mem_address    = mem_address_reg;
  assign mem_read       = mem_read_reg;
  assign mem_write      = mem_write_reg;
  assign mem_writedata  = mem_writedata_reg;
  assign mem_byteenable = mem_byteenable_reg;
  assign grant_d        = grant_d_reg;
  assign i_ack          = i_ack_reg;
  assign d_ack          = d_ack_reg;
  assign i_rdata        = i_rdata_reg;
  assign d_rdata        = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: RAM model with waitrequest, a transaction
// timeline model predicting every output each cycle, directed scenarios with
// literal expectations, then randomized traffic from both requesters.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_STREAK = 4;
  localparam int RD_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest = 1'b0;
  logic        grant_d;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest), .grant_d(grant_d)
  );

  function automatic logic [31:0] init_word(input int k);
    if (k == 0) return 32'h2402000A;
    return 32'h1000_0000 + 32'(k) * 32'h0001_0203;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'hBFC0_0000 + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model (16 words, addr[5:2]) ----------------
  logic [31:0] ram [16];
  logic [31:0] rd_pipe [RD_LATENCY];
  bit          ram_loaded = 1'b0;
  assign mem_readdata = rd_pipe[RD_LATENCY-1];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 16; k++) ram[k] <= init_word(k);
      ram_loaded <= 1'b1;
    end else begin
      if (mem_read && !mem_waitrequest) rd_pipe[0] <= ram[mem_address[5:2]];
      for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
      if (mem_write && !mem_waitrequest)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address[5:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end

  // ---------------- transaction timeline model ----------------
  // One transaction at a time: granted at cycle t_grant, on the bus from
  // t_grant+1 until the first cycle without waitrequest (t_accept), acked
  // 1 cycle later for stores or 1+RD_LATENCY cycles later for loads.
  logic [31:0] model_mem [16];
  longint      cyc, t_grant, t_accept, t_ack;
  bit          m_active, m_port_d, m_write;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [3:0]  m_be;
  int          m_streak;
  bit          e_read, e_write, e_iack, e_dack, e_grant_d;
  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
  logic [3:0]  e_be;

  initial begin
    for (int k = 0; k < 16; k++) model_mem[k] = init_word(k);
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        cyc = 0; m_active = 0; m_streak = 0; t_ack = -1; t_accept = -1; t_grant = 0;
        e_read = 0; e_write = 0; e_iack = 0; e_dack = 0; e_grant_d = 0;
        e_irdata = '0; e_drdata = '0; e_addr = '0; e_wdata = '0; e_be = '0; m_rd = '0;
      end else begin
        if (m_active && cyc == t_ack) begin
          m_active = 0;
        end else if (!m_active) begin
          if (i_req || d_req) begin
            m_port_d = d_req && !(i_req && m_streak == MAX_STREAK);
            if (m_port_d) begin
              m_streak = i_req ? ((m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK) : 0;
              m_write = d_write; m_addr = d_addr; m_wdata = d_wdata;
              m_be = d_write ? d_byteenable : 4'hF;
            end else begin
              m_streak = 0; m_write = 0; m_addr = i_addr; m_wdata = '0; m_be = 4'hF;
            end
            m_active = 1; t_grant = cyc; t_accept = -1; t_ack = -1;
            e_grant_d = m_port_d;
          end
        end else if (t_accept < 0) begin
          if (!mem_waitrequest) begin
            t_accept = cyc;
            if (m_write) begin
              t_ack = cyc + 1;
              for (int b = 0; b < 4; b++)
                if (m_be[b]) model_mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
              t_ack = cyc + 1 + RD_LATENCY;
              m_rd = model_mem[m_addr[5:2]];
            end
          end
        end
        cyc++;
        e_read  = m_active && (t_accept < 0) && !m_write;
        e_write = m_active && (t_accept < 0) && m_write;
        e_addr = m_addr; e_wdata = m_wdata; e_be = m_be;
        e_iack = m_active && (cyc == t_ack) && !m_port_d;
        e_dack = m_active && (cyc == t_ack) && m_port_d;
        if (e_iack) e_irdata = m_rd;
        if (e_dack && !m_write) e_drdata = m_rd;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && chk_en) begin
        chk("cyc_mem_read", {31'd0, mem_read}, {31'd0, e_read});
        chk("cyc_mem_write", {31'd0, mem_write}, {31'd0, e_write});
        if (e_read || e_write) begin
          chk("cyc_mem_address", mem_address, e_addr);
          chk("cyc_mem_byteenable", {28'd0, mem_byteenable}, {28'd0, e_be});
        end
        if (e_write) chk("cyc_mem_writedata", mem_writedata, e_wdata);
        chk("cyc_i_ack", {31'd0, i_ack}, {31'd0, e_iack});
        chk("cyc_d_ack", {31'd0, d_ack}, {31'd0, e_dack});
        chk("cyc_grant_d", {31'd0, grant_d}, {31'd0, e_grant_d});
        chk("cyc_i_rdata", i_rdata, e_irdata);
        chk("cyc_d_rdata", d_rdata, e_drdata);
        if (e_iack) $display("[TB] I load  addr=%08h data=%08h", e_addr, e_irdata);
        if (e_dack) $display("[TB] D %s addr=%08h data=%08h", m_write ? "store" : "load ",
                             e_addr, m_write ? e_wdata : e_drdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle_drop();
    tick();
    i_req = 1'b0; d_req = 1'b0; mem_waitrequest = 1'b0;
  endtask

  // Presents a request in the current cycle (cycle 0) and returns the cycle
  // number of its ack; waitrequest is raised for cycles 1..wait_cycles.
  task automatic run_req(input bit port_d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int wait_cycles, output int lat, output logic [31:0] rdata);
    int n;
    lat = -1; rdata = '0; n = 0;
    if (port_d) begin
      d_req = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata; d_byteenable = be;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    mem_waitrequest = 1'b0;
    while (lat < 0 && n < 40) begin
      tick();
      n++;
      mem_waitrequest = (n <= wait_cycles);
      if (port_d ? d_ack : i_ack) begin
        lat = n;
        rdata = port_d ? d_rdata : i_rdata;
      end
    end
    if (lat < 0) begin
      tests_run++; tests_failed++;
      $display("FAIL run_req_timeout: got no ack in 40 cycles, expected an ack (addr %08h)", addr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [31:0] rd;
    logic [9:0] order;
    int cnt, n;
    bit i_ack_prev, d_ack_prev;

    // reset state
    #12;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_grant_d", {31'd0, grant_d}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick(); tick();

    // lone fetch: mem_read in cycle 1, ack with data in cycle 3
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    tick();
    chk("t2_mem_read_c1", {31'd0, mem_read}, 32'd1);
    chk("t2_mem_address_c1", mem_address, 32'hBFC0_0000);
    tick();
    chk("t2_no_ack_c2", {31'd0, i_ack}, 32'd0);
    tick();
    chk("t2_i_ack_c3", {31'd0, i_ack}, 32'd1);
    chk("t2_i_rdata_c3", i_rdata, 32'h2402000A);
    next_cycle_drop();

    // store then load the same address
    run_req(1'b1, 1'b1, 32'hBFC0_0010, 32'hDEADBEEF, 4'hF, 0, lat, rd);
    chk("t3_store_latency", 32'(lat), 32'd2);
    next_cycle_drop();
    run_req(1'b1, 1'b0, 32'hBFC0_0010, 32'h0, 4'hF, 0, lat, rd);
    chk("t3_load_latency", 32'(lat), 32'd3);
    chk("t3_load_data", rd, 32'hDEADBEEF);
    next_cycle_drop();

    // back-to-back stores: second request presented the cycle after the first ack
    run_req(1'b1, 1'b1, 32'hBFC0_0014, 32'hCAFE0001, 4'b0101, 0, lat, rd);
    chk("t6_first_latency", 32'(lat), 32'd2);
    tick();
    run_req(1'b1, 1'b1, 32'hBFC0_0018, 32'hCAFE0002, 4'b1111, 0, lat, rd);
    chk("t6_second_latency", 32'(lat), 32'd2);
    next_cycle_drop();
    tick();
    chk("t6_no_extra_ack", {31'd0, d_ack}, 32'd0);

    // both requesters held: starvation guard gives D,D,D,D,I,...
    i_req = 1'b1; i_addr = 32'hBFC0_0004;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'hBFC0_0008;
    order = '0; cnt = 0; n = 0;
    while (cnt < 10 && n < 300) begin
      tick();
      n++;
      if (d_ack) begin order = {order[8:0], 1'b1}; cnt++; end
      else if (i_ack) begin order = {order[8:0], 1'b0}; cnt++; end
    end
    chk("t4_grant_count", 32'(cnt), 32'd10);
    chk("t4_grant_order", {22'd0, order}, {22'd0, 10'b1111011110});
    next_cycle_drop();
    tick();

    // waitrequest stalls: each stalled cycle adds one to the latency
    run_req(1'b1, 1'b1, 32'hBFC0_0020, 32'h12345678, 4'hF, 3, lat, rd);
    chk("t5_store_wait_latency", 32'(lat), 32'd5);
    next_cycle_drop();
    run_req(1'b1, 1'b0, 32'hBFC0_0020, 32'h0, 4'hF, 2, lat, rd);
    chk("t5_load_wait_latency", 32'(lat), 32'd5);
    chk("t5_load_data", rd, 32'h12345678);
    next_cycle_drop();
    tick();

    // reset in the middle of ISSUE
    i_req = 1'b1; i_addr = 32'hBFC0_0000; mem_waitrequest = 1'b1;
    tick();
    chk("t1_issue_before_reset", {31'd0, mem_read}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_mem_read_async", {31'd0, mem_read}, 32'd0);
    chk("t1_mem_write_async", {31'd0, mem_write}, 32'd0);
    chk("t1_acks_async", {30'd0, i_ack, d_ack}, 32'd0);
    chk("t1_grant_d_async", {31'd0, grant_d}, 32'd0);
    i_req = 1'b0; mem_waitrequest = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("t1_idle_after_reset", {30'd0, mem_read, i_ack}, 32'd0);
    run_req(1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 0, lat, rd);
    chk("t1_fetch_latency", 32'(lat), 32'd3);
    chk("t1_fetch_data", rd, 32'h2402000A);
    next_cycle_drop();
    tick();

    // randomized traffic from both ports
    i_ack_prev = 1'b0; d_ack_prev = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (i_req) begin
        if (i_ack_prev) begin
          i_req = ($urandom_range(0, 1) == 1);
          i_addr = rand_addr();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = rand_addr();
      end
      if (d_req) begin
        if (d_ack_prev) begin
          d_req = ($urandom_range(0, 9) != 0);
          d_write = ($urandom_range(0, 1) == 1); d_addr = rand_addr();
          d_wdata = $urandom; d_byteenable = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 1) == 0) begin
        d_req = 1'b1;
        d_write = ($urandom_range(0, 1) == 1); d_addr = rand_addr();
        d_wdata = $urandom; d_byteenable = 4'($urandom_range(0, 15));
      end
      mem_waitrequest = ($urandom_range(0, 3) == 0);
      i_ack_prev = i_ack; d_ack_prev = d_ack;
    end
    next_cycle_drop();
    for (int k = 0; k < 20; k++) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
